mdio_resp: RTL and testbench



---
 rtl/mdio_pkg.sv | 30 +++
 rtl/mdio_sync.sv | 32 +++
 rtl/mdio_resp.sv | 227 ++++++++++++++++++++++
 tb/tb_mdio_resp.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// Shared constants for the Clause-22 MDIO responder: opcodes, FSM encodings,
// register addresses and reset values.
package mdio_pkg;

  localparam logic [1:0] OP_RD = 2'b10;
  localparam logic [1:0] OP_WR = 2'b01;

  typedef logic [3:0] state_t;

  localparam state_t StIdle  = 4'd0;
  localparam state_t StSt    = 4'd1;
  localparam state_t StOp    = 4'd2;
  localparam state_t StPhyad = 4'd3;
  localparam state_t StRegad = 4'd4;
  localparam state_t StTa    = 4'd5;
  localparam state_t StWdata = 4'd6;
  localparam state_t StRdata = 4'd7;
  localparam state_t StSkip  = 4'd8;

  localparam logic [4:0] REG_CTRL   = 5'd0;
  localparam logic [4:0] REG_STATUS = 5'd1;
  localparam logic [4:0] REG_ID1    = 5'd2;
  localparam logic [4:0] REG_ID2    = 5'd3;

  localparam logic [15:0] REG0_RST  = 16'h1140;
  localparam logic [15:0] REG1_BASE = 16'h796D;

  localparam int unsigned PREAMBLE_LEN = 32;

endpackage

// File: rtl/mdio_sync.sv
// Two-flop synchronizers for MDC/MDIO and MDC edge pulses in the clk domain.
module mdio_sync (
  input  logic clk,
  input  logic rst,
  input  logic mdc_i,
  input  logic mdio_i,
  output logic mdc_rise_o,
  output logic mdc_fall_o,
  output logic mdio_o
);

  logic [1:0] mdc_q;
  logic [1:0] mdio_q;
  logic       mdc_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mdc_q      <= 2'b00;
      mdio_q     <= 2'b11;
      mdc_prev_q <= 1'b0;
    end else begin
      mdc_q      <= {mdc_q[0], mdc_i};
      mdio_q     <= {mdio_q[0], mdio_i};
      mdc_prev_q <= mdc_q[1];
    end
  end

  assign mdc_rise_o = mdc_q[1] & ~mdc_prev_q;
  assign mdc_fall_o = ~mdc_q[1] & mdc_prev_q;
  assign mdio_o     = mdio_q[1];

endmodule

// File: rtl/mdio_resp.sv
// Clause-22 MDIO responder: frame engine plus a 32x16 PHY management register file.
module mdio_resp
  import mdio_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR    = 5'h04,
  parameter logic [31:0] PHY_ID      = 32'h001C_C916,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        eth_mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        link_up,
  output logic        reg_wr_stb,
  output logic [4:0]  reg_addr,
  output logic [15:0] reg_wdata,
  output logic [15:0] ctrl_reg
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [5:0]  PreMax = 6'(PREAMBLE_LEN);

  logic mdc_rise, mdc_fall, mdio_s;

  mdio_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .mdc_i      (eth_mdc),
    .mdio_i     (mdio_i),
    .mdc_rise_o (mdc_rise),
    .mdc_fall_o (mdc_fall),
    .mdio_o     (mdio_s)
  );

  state_t          state_q, state_d;
  logic [4:0]      pos_q, pos_d;      // frame bit index; ST's first bit is 0
  logic [5:0]      pre_q, pre_d;
  logic [14:0]     sr_q, sr_d;
  logic [15:0]     rsh_q, rsh_d;
  logic            is_rd_q, is_rd_d;
  logic            o_q, o_d, oe_q, oe_d, stb_q, stb_d;
  logic [4:0]      addr_q, addr_d;
  logic [15:0]     wdata_q, wdata_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [15:0]     regs_q [32];
  logic [15:0]     regs_d [32];

  logic [4:0]  rd_addr;
  logic [15:0] rd_val;
  logic [15:0] wval;

  assign rd_addr = {sr_q[3:0], mdio_s};
  assign wval    = {sr_q, mdio_s};

  always_comb begin
    rd_val = regs_q[rd_addr];
    case (rd_addr)
      REG_STATUS: rd_val = {REG1_BASE[15:3], link_up, REG1_BASE[1:0]};
      REG_ID1:    rd_val = PHY_ID[31:16];
      REG_ID2:    rd_val = PHY_ID[15:0];
      default:    ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    pre_d   = pre_q;
    sr_d    = sr_q;
    rsh_d   = rsh_q;
    is_rd_d = is_rd_q;
    o_d     = o_q;
    oe_d    = oe_q;
    stb_d   = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    tmo_d   = tmo_q;
    regs_d  = regs_q;

    if (mdc_rise) begin
      sr_d  = {sr_q[13:0], mdio_s};
      tmo_d = '0;
      if (state_q != StIdle) pos_d = pos_q + 5'd1;
      case (state_q)
        StIdle: begin
          if (mdio_s) begin
            if (pre_q != PreMax) pre_d = pre_q + 6'd1;
          end else if (pre_q == PreMax) begin
            state_d = StSt;
            pos_d   = 5'd1;
            pre_d   = '0;
          end else begin
            pre_d = '0;
          end
        end
        StSt: state_d = mdio_s ? StOp : StSkip;
        StOp: begin
          if (pos_q == 5'd3) begin
            case ({sr_q[0], mdio_s})
              OP_RD: begin
                is_rd_d = 1'b1;
                state_d = StPhyad;
              end
              OP_WR: begin
                is_rd_d = 1'b0;
                state_d = StPhyad;
              end
              default: state_d = StSkip;
            endcase
          end
        end
        StPhyad: begin
          if (pos_q == 5'd8) state_d = (rd_addr == PHY_ADDR) ? StRegad : StSkip;
        end
        StRegad: begin
          if (pos_q == 5'd13) begin
            addr_d  = rd_addr;
            rsh_d   = rd_val;
            state_d = StTa;
          end
        end
        StTa: begin
          if (pos_q == 5'd15) state_d = is_rd_q ? StRdata : StWdata;
        end
        StWdata: begin
          if (pos_q == 5'd31) begin
            stb_d   = 1'b1;
            wdata_d = wval;
            state_d = StIdle;
            pre_d   = '0;
            if (addr_q == REG_CTRL) begin
              if (wval[15]) begin
                for (int i = 1; i < 32; i++) regs_d[i] = '0;
                regs_d[0] = REG0_RST;
              end else begin
                regs_d[0] = wval;
              end
            end else if (addr_q > REG_ID2) begin
              regs_d[addr_q] = wval;
            end
          end
        end
        StSkip: begin
          if (pos_q == 5'd31) begin
            state_d = StIdle;
            pre_d   = '0;
          end
        end
        default: ;
      endcase
    end

    // Read turnaround: take the bus for the second TA bit, then shift data out.
    if (mdc_fall) begin
      if (state_q == StTa && is_rd_q && pos_q == 5'd15) begin
        oe_d = 1'b1;
        o_d  = 1'b0;
      end else if (state_q == StRdata) begin
        if (pos_q == 5'd0) begin
          oe_d    = 1'b0;
          o_d     = 1'b1;
          state_d = StIdle;
          pre_d   = '0;
        end else begin
          o_d   = rsh_q[15];
          rsh_d = {rsh_q[14:0], 1'b0};
        end
      end
    end

    if (state_q == StIdle) begin
      tmo_d = '0;
    end else if (!mdc_rise) begin
      if (tmo_q == TmoW'(TIMEOUT_CYC - 1)) begin
        state_d = StIdle;
        oe_d    = 1'b0;
        o_d     = 1'b1;
        pre_d   = '0;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + TmoW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pos_q   <= '0;
      pre_q   <= '0;
      sr_q    <= '0;
      rsh_q   <= '0;
      is_rd_q <= 1'b0;
      o_q     <= 1'b1;
      oe_q    <= 1'b0;
      stb_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      tmo_q   <= '0;
      for (int i = 0; i < 32; i++) regs_q[i] <= (i == 0) ? REG0_RST : 16'h0000;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      pre_q   <= pre_d;
      sr_q    <= sr_d;
      rsh_q   <= rsh_d;
      is_rd_q <= is_rd_d;
      o_q     <= o_d;
      oe_q    <= oe_d;
      stb_q   <= stb_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      tmo_q   <= tmo_d;
      regs_q  <= regs_d;
    end
  end

  assign mdio_o     = o_q;
  assign mdio_oe    = oe_q;
  assign reg_wr_stb = stb_q;
  assign reg_addr   = addr_q;
  assign reg_wdata  = wdata_q;
  assign ctrl_reg   = regs_q[0];

endmodule

// File: tb/tb_mdio_resp.sv
// Bench for mdio_resp: bit-level MDIO master, vector table, read-data scoreboard.
module tb_mdio_resp;

  localparam logic [4:0]  PhyAddr    = 5'h04;
  localparam int unsigned TimeoutCyc = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        eth_mdc;
  logic        mdio_i;
  logic        mdio_o;
  logic        mdio_oe;
  logic        link_up;
  logic        reg_wr_stb;
  logic [4:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic [15:0] ctrl_reg;

  logic master_oe;
  logic master_val;

  int n_cmp = 0;
  int n_err = 0;
  int stb_hi = 0;
  int oe_hi = 0;

  logic [15:0] exp_q [$];

  typedef struct {
    bit          is_rd;
    logic [4:0]  phy;
    logic [4:0]  ra;
    logic [15:0] d;
    bit          link;
  } vec_t;

  vec_t vecs [13];

  always #5 clk = ~clk;

  // Open-drain style bus with a pull-up when nobody drives.
  assign mdio_i = master_oe ? master_val : (mdio_oe ? mdio_o : 1'b1);

  mdio_resp #(
    .PHY_ADDR    (PhyAddr),
    .PHY_ID      (32'h001C_C916),
    .TIMEOUT_CYC (TimeoutCyc)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .eth_mdc    (eth_mdc),
    .mdio_i     (mdio_i),
    .mdio_o     (mdio_o),
    .mdio_oe    (mdio_oe),
    .link_up    (link_up),
    .reg_wr_stb (reg_wr_stb),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .ctrl_reg   (ctrl_reg)
  );

  always @(negedge clk) begin
    if (reg_wr_stb) stb_hi <= stb_hi + 1;
    if (mdio_oe) oe_hi <= oe_hi + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One MDC period; the bus is sampled just before the rising edge.
  task automatic mdc_cycle(input bit drv, input bit val,
                           output logic s_val, output logic s_oe, output logic s_o);
    eth_mdc = 1'b0;
    wclk(2);
    master_oe  = drv;
    master_val = val;
    wclk(3);
    s_val   = mdio_i;
    s_oe    = mdio_oe;
    s_o     = mdio_o;
    eth_mdc = 1'b1;
    wclk(5);
  endtask

  task automatic send_bit(input bit b);
    logic a, c, e;
    mdc_cycle(1'b1, b, a, c, e);
  endtask

  task automatic frame(input bit is_rd, input logic [4:0] phy, input logic [4:0] ra,
                       input logic [15:0] d, input int npre, input string tag);
    logic [13:0] hdr;
    logic [15:0] rd;
    logic        sv, so, sd;
    int          stb0, oe0;
    bit          hit;
    hit  = (phy == PhyAddr) && (npre >= 32);
    stb0 = stb_hi;
    oe0  = oe_hi;
    hdr  = {2'b01, (is_rd ? 2'b10 : 2'b01), phy, ra};
    for (int i = 0; i < npre; i++) send_bit(1'b1);
    for (int i = 13; i >= 0; i--) send_bit(hdr[i]);
    if (is_rd) begin
      exp_q.push_back(hit ? d : 16'hFFFF);
      mdc_cycle(1'b0, 1'b1, sv, so, sd);
      check({tag, " ta0_oe"}, 32'(so), 32'(0));
      mdc_cycle(1'b0, 1'b1, sv, so, sd);
      check({tag, " ta1_oe"}, 32'(so), 32'(hit));
      if (hit) check({tag, " ta1_val"}, 32'(sv), 32'(0));
      for (int i = 15; i >= 0; i--) begin
        mdc_cycle(1'b0, 1'b1, sv, so, sd);
        rd[i] = sv;
      end
      mdc_cycle(1'b0, 1'b1, sv, so, sd);
      check({tag, " release_oe"}, 32'(so), 32'(0));
      check({tag, " rdata"}, 32'(rd), 32'(exp_q.pop_front()));
    end else begin
      send_bit(1'b1);
      send_bit(1'b0);
      for (int i = 15; i >= 0; i--) send_bit(d[i]);
      send_bit(1'b1);
      check({tag, " stb_cycles"}, 32'(stb_hi - stb0), hit ? 32'd1 : 32'd0);
      if (hit) begin
        check({tag, " reg_addr"}, 32'(reg_addr), 32'(ra));
        check({tag, " reg_wdata"}, 32'(reg_wdata), 32'(d));
      end
    end
    if (!hit) check({tag, " oe_quiet"}, 32'(oe_hi - oe0), 32'd0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic sv, so, sd;

    vecs[0]  = '{1'b1, 5'd4, 5'd2,  16'h001C, 1'b0};
    vecs[1]  = '{1'b1, 5'd4, 5'd3,  16'hC916, 1'b0};
    vecs[2]  = '{1'b1, 5'd4, 5'd0,  16'h1140, 1'b0};
    vecs[3]  = '{1'b1, 5'd4, 5'd1,  16'h7969, 1'b0};
    vecs[4]  = '{1'b0, 5'd4, 5'd16, 16'hABCD, 1'b0};
    vecs[5]  = '{1'b1, 5'd4, 5'd16, 16'hABCD, 1'b0};
    vecs[6]  = '{1'b0, 5'd5, 5'd16, 16'h5555, 1'b0};
    vecs[7]  = '{1'b1, 5'd4, 5'd16, 16'hABCD, 1'b0};
    vecs[8]  = '{1'b1, 5'd5, 5'd2,  16'h001C, 1'b0};
    vecs[9]  = '{1'b0, 5'd4, 5'd1,  16'hFFFF, 1'b0};
    vecs[10] = '{1'b1, 5'd4, 5'd1,  16'h796D, 1'b1};
    vecs[11] = '{1'b0, 5'd4, 5'd31, 16'h5A5A, 1'b0};
    vecs[12] = '{1'b1, 5'd4, 5'd31, 16'h5A5A, 1'b0};

    rst        = 1'b1;
    eth_mdc    = 1'b0;
    master_oe  = 1'b1;
    master_val = 1'b1;
    link_up    = 1'b0;
    wclk(3);
    check("rst mdio_o", 32'(mdio_o), 32'd1);
    check("rst mdio_oe", 32'(mdio_oe), 32'd0);
    check("rst reg_wr_stb", 32'(reg_wr_stb), 32'd0);
    check("rst reg_addr", 32'(reg_addr), 32'd0);
    check("rst reg_wdata", 32'(reg_wdata), 32'd0);
    check("rst ctrl_reg", 32'(ctrl_reg), 32'h1140);
    rst = 1'b0;
    wclk(2);

    for (int i = 0; i < 13; i++) begin
      link_up = vecs[i].link;
      frame(vecs[i].is_rd, vecs[i].phy, vecs[i].ra, vecs[i].d, 32, $sformatf("vec%0d", i));
    end
    link_up = 1'b0;

    // Preamble length boundary: 31 ones must not start a frame, 32 must.
    send_bit(1'b0);
    frame(1'b0, 5'd4, 5'd7, 16'h1111, 31, "pre31_wr");
    frame(1'b1, 5'd4, 5'd7, 16'h0000, 32, "pre31_chk");
    frame(1'b0, 5'd4, 5'd7, 16'h1111, 32, "pre32_wr");
    frame(1'b1, 5'd4, 5'd7, 16'h1111, 32, "pre32_chk");

    // Soft reset through reg0 bit 15.
    frame(1'b0, 5'd4, 5'd16, 16'h1234, 32, "sr_wr16");
    frame(1'b0, 5'd4, 5'd0, 16'h0100, 32, "sr_wr0");
    check("sr ctrl before", 32'(ctrl_reg), 32'h0100);
    frame(1'b0, 5'd4, 5'd0, 16'h8000, 32, "sr_rst");
    check("sr ctrl after", 32'(ctrl_reg), 32'h1140);
    frame(1'b1, 5'd4, 5'd16, 16'h0000, 32, "sr_rd16");
    frame(1'b1, 5'd4, 5'd0, 16'h1140, 32, "sr_rd0");

    // MDC stalls mid-REGAD; the engine must time out back to IDLE.
    for (int i = 0; i < 32; i++) send_bit(1'b1);
    begin
      logic [10:0] part;
      part = {2'b01, 2'b10, 5'd4, 2'b00};
      for (int i = 10; i >= 0; i--) send_bit(part[i]);
    end
    wclk(TimeoutCyc + 10);
    check("tmo oe", 32'(mdio_oe), 32'd0);
    link_up = 1'b1;
    frame(1'b1, 5'd4, 5'd1, 16'h796D, 32, "tmo_rd1");
    link_up = 1'b0;

    // Hard reset in the middle of read data.
    frame(1'b0, 5'd4, 5'd0, 16'h0100, 32, "hr_wr0");
    for (int i = 0; i < 32; i++) send_bit(1'b1);
    begin
      logic [13:0] hdr;
      hdr = {2'b01, 2'b10, 5'd4, 5'd3};
      for (int i = 13; i >= 0; i--) send_bit(hdr[i]);
    end
    for (int i = 0; i < 6; i++) mdc_cycle(1'b0, 1'b1, sv, so, sd);
    check("hr oe before rst", 32'(mdio_oe), 32'd1);
    rst = 1'b1;
    wclk(1);
    check("hr oe after rst", 32'(mdio_oe), 32'd0);
    check("hr ctrl_reg", 32'(ctrl_reg), 32'h1140);
    check("hr reg_addr", 32'(reg_addr), 32'd0);
    check("hr reg_wdata", 32'(reg_wdata), 32'd0);
    rst        = 1'b0;
    master_oe  = 1'b1;
    master_val = 1'b1;
    wclk(2);
    frame(1'b1, 5'd4, 5'd31, 16'h0000, 32, "hr_rd31");
    frame(1'b1, 5'd4, 5'd2, 16'h001C, 32, "hr_rd2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
